// File: rtl/sigmoid_arbiter_pkg.sv
// Shared constants and types for the sigmoid arbiter slice.
// Values are Q6.9 fixed point, so 1.0 is 0x0200.
// The PWL constants describe the sigmoid curve that the shared unit implements.
package sigmoid_arb_pkg;

    localparam int          DW_C      = 16;
    localparam int          FRAC_BITS = 9;
    localparam logic [15:0] ONE_Q     = 16'h0200;

    // Ramp offset at x = 0 and the upper clamp of the piecewise-linear curve
    localparam logic [15:0] PWL_BIAS  = 16'h00FD;
    localparam logic [15:0] PWL_SAT   = 16'h0201;

    // One in-flight operation: whether it is real, and which requester owns it
    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
    } tag_t;

endpackage

// File: rtl/sigmoid_arbiter_if.sv
// Requester-side bus of the sigmoid arbiter.
// Lane i of every packed vector belongs to requester i.
interface sigmoid_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 16
);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*DW-1:0] req_x;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [N_REQ-1:0]    rsp_ready;
    logic [N_REQ*DW-1:0] rsp_y;

    modport master (
        output req_valid, req_x, rsp_ready,
        input  req_ready, rsp_valid, rsp_y
    );

    modport slave (
        input  req_valid, req_x, rsp_ready,
        output req_ready, rsp_valid, rsp_y
    );

endinterface

// File: rtl/sigmoidPWL.sv
// Piecewise-linear sigmoid in Q6.9 with LAT output register stages.
// For x >= 0: y = min(PWL_BIAS + |x|/4, PWL_SAT).
// For x < 0 the curve is mirrored around 0.5: y = max(ONE_Q - y(|x|), 0).
module sigmoidPWL
    import sigmoid_arb_pkg::*;
#(
    parameter int DW  = DW_C,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] x_i,
    output logic [DW-1:0] y_o
);

    logic [DW:0]   absX;
    logic [DW+1:0] ramp;
    logic [DW+1:0] magY;
    logic [DW-1:0] yComb;
    logic [DW-1:0] pipe_q [LAT];

    // Evaluate the curve on the magnitude, then mirror it for negative inputs
    always_comb begin
        absX  = x_i[DW-1] ? ((~{1'b1, x_i}) + (DW+1)'(1)) : {1'b0, x_i};
        ramp  = (DW+2)'(absX >> 2) + (DW+2)'(PWL_BIAS);
        magY  = (ramp > (DW+2)'(PWL_SAT)) ? (DW+2)'(PWL_SAT) : ramp;
        yComb = DW'(magY);
        if (x_i[DW-1]) begin
            if (magY >= (DW+2)'(ONE_Q)) begin
                yComb = '0;
            end else begin
                yComb = DW'((DW+2)'(ONE_Q) - magY);
            end
        end
    end

    // Output pipeline; its contents only matter when a tag says so
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) pipe_q[s] <= '0;
        end else begin
            pipe_q[0] <= yComb;
            for (int s = 1; s < LAT; s++) pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign y_o = pipe_q[LAT-1];

endmodule

// File: rtl/sigmoid_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first eligible index at or after ptr,
// wrapping modulo N. The pointer itself is kept by the caller.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic          found;
    logic [PW-1:0] cand;

    // Walk the candidates in priority order and keep only the first hit
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = PW'((int'(ptr) + k) % N);
            if (!found && elig[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sigmoid_arbiter.sv
// Shares one sigmoidPWL unit among N_REQ requesters with round-robin issue,
// a tag pipeline that follows each operand through the unit, and a one-entry
// response register per requester.
// Optional: define SIGMOID_ARB_STALL_CNT_EN to add the stall_cnt port.
module sigmoid_arbiter
    import sigmoid_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = DW_C,
    parameter int PWL_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    sigmoid_arbiter_if.slave bus,
    output logic             busy
`ifdef SIGMOID_ARB_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] rspValid_q, rspValid_d;
    logic [DW-1:0]    rspY_q [N_REQ];
    logic [DW-1:0]    rspY_d [N_REQ];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    tag_t             tagPipe_q [PWL_LAT];
    tag_t             tagIn;
    tag_t             tagOut;
    logic [N_REQ-1:0] rspFire;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] gnt;
    logic [PTR_W-1:0] gntIdx;
    logic             anyGnt;
    logic [DW-1:0]    pwlX;
    logic [DW-1:0]    pwlY;

    // A slot whose response drains this cycle may be granted again at once.
    // Grants are masked while reset is asserted so req_ready stays low.
    assign rspFire = rspValid_q & bus.rsp_ready;
    assign elig    = bus.req_valid & (~pending_q | rspFire) & {N_REQ{rst_n}};

    rr_arbiter #(.N(N_REQ), .PW(PTR_W)) uArb (
        .elig    (elig),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gntIdx)
    );

    assign bus.req_ready = gnt;
    assign anyGnt        = |gnt;

    // Steer the granted operand into the unit; idle cycles feed zero
    always_comb begin
        pwlX = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) pwlX = bus.req_x[i*DW +: DW];
        end
    end

    sigmoidPWL #(.DW(DW), .LAT(PWL_LAT)) uPwl (
        .clk   (clk),
        .rst_n (rst_n),
        .x_i   (pwlX),
        .y_o   (pwlY)
    );

    // Next pointer, credit bits and the tag that enters the pipeline
    always_comb begin
        ptr_d = ptr_q;
        if (anyGnt) begin
            ptr_d = (gntIdx == PTR_W'(N_REQ - 1)) ? '0 : gntIdx + PTR_W'(1);
        end
        pending_d  = (pending_q & ~rspFire) | gnt;
        tagIn.vld  = anyGnt;
        tagIn.idx  = 3'(gntIdx);
    end

    assign tagOut = tagPipe_q[PWL_LAT-1];

    // Drain clears a slot; a tag leaving the pipeline fills its owner's slot
    always_comb begin
        rspValid_d = rspValid_q & ~rspFire;
        for (int i = 0; i < N_REQ; i++) begin
            rspY_d[i] = rspY_q[i];
            if (tagOut.vld && (tagOut.idx == 3'(i))) begin
                rspValid_d[i] = 1'b1;
                rspY_d[i]     = pwlY;
            end
        end
    end

    // Tag pipeline shifts every cycle, in lockstep with the unit's stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < PWL_LAT; s++) tagPipe_q[s] <= '0;
        end else begin
            tagPipe_q[0] <= tagIn;
            for (int s = 1; s < PWL_LAT; s++) tagPipe_q[s] <= tagPipe_q[s-1];
        end
    end

    // Arbitration pointer, credit bits and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            pending_q  <= '0;
            rspValid_q <= '0;
            for (int i = 0; i < N_REQ; i++) rspY_q[i] <= '0;
        end else begin
            ptr_q      <= ptr_d;
            pending_q  <= pending_d;
            rspValid_q <= rspValid_d;
            for (int i = 0; i < N_REQ; i++) rspY_q[i] <= rspY_d[i];
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : gPack
        assign bus.rsp_y[gi*DW +: DW] = rspY_q[gi];
    end

    assign bus.rsp_valid = rspValid_q;
    assign busy          = |pending_q;

`ifdef SIGMOID_ARB_STALL_CNT_EN
    logic [31:0] stallCnt_q;

    // Count cycles where someone asks but nobody is granted, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
        end else if ((|bus.req_valid) && !anyGnt && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_q <= stallCnt_q + 32'd1;
        end
    end

    assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Self-checking bench for sigmoid_arbiter with a transaction-level model.
// Optional: define SIGMOID_ARB_STALL_CNT_EN to also check stall_cnt.
module tb_sigmoid_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef SIGMOID_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    sigmoid_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

    sigmoid_arbiter #(.N_REQ(N), .DW(DW), .PWL_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
`ifdef SIGMOID_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: per-requester credit, response slot and in-flight result
    logic [N-1:0]    mPending;
    logic [N-1:0]    mRspValid;
    logic [N*DW-1:0] mRspY;
    int              mInfDue [N];
    logic [DW-1:0]   mInfY [N];
    int              mPtr;
    int              cycleNo;
    int              mStall;
    int              expGnt;
    logic [N-1:0]    expReady;

    // Sigmoid curve of the shared unit, from plain integer arithmetic
    function automatic logic [DW-1:0] refSigmoid(input logic [DW-1:0] x);
        int v, a, p;
        v = int'($signed(x));
        a = (v < 0) ? -v : v;
        p = 253 + a / 4;
        if (p > 513) p = 513;
        if (v < 0) begin
            p = 512 - p;
            if (p < 0) p = 0;
        end
        return DW'(p);
    endfunction

    task automatic modelReset();
        mPending  = '0;
        mRspValid = '0;
        mRspY     = '0;
        mPtr      = 0;
        cycleNo   = 0;
        mStall    = 0;
        for (int i = 0; i < N; i++) begin
            mInfDue[i] = -1;
            mInfY[i]   = '0;
        end
    endtask

    // Who should win this cycle, given the model state and the driven inputs
    task automatic modelEval();
        logic [N-1:0] e;
        int c;
        e = bus.req_valid & (~mPending | (mRspValid & bus.rsp_ready));
        expGnt = -1;
        for (int k = 0; k < N; k++) begin
            c = (mPtr + k) % N;
            if (expGnt < 0 && e[c]) expGnt = c;
        end
        expReady = '0;
        if (expGnt >= 0) expReady[expGnt] = 1'b1;
    endtask

    task automatic modelAdvance();
        if ((|bus.req_valid) && expGnt < 0) mStall++;
        for (int i = 0; i < N; i++) begin
            if (mRspValid[i] && bus.rsp_ready[i]) begin
                mRspValid[i] = 1'b0;
                mPending[i]  = 1'b0;
            end
        end
        if (expGnt >= 0) begin
            mPending[expGnt] = 1'b1;
            mPtr             = (expGnt + 1) % N;
            mInfDue[expGnt]  = cycleNo + 2;
            mInfY[expGnt]    = refSigmoid(bus.req_x[expGnt*DW +: DW]);
        end
        cycleNo++;
        for (int i = 0; i < N; i++) begin
            if (mInfDue[i] == cycleNo) begin
                mRspValid[i]         = 1'b1;
                mRspY[i*DW +: DW]    = mInfY[i];
                mInfDue[i]           = -1;
            end
        end
    endtask

    // Drive one cycle's inputs and work out the expected grant
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*DW-1:0] x,
                                 input logic [N-1:0] r);
        bus.req_valid = v;
        bus.req_x     = x;
        bus.rsp_ready = r;
        modelEval();
    endtask

    task automatic endCycle();
        @(posedge clk);
        modelAdvance();
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        applyStimulus('0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    // Reset values while inputs are busy
    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '1;
        bus.req_x     = {$urandom, $urandom};
        bus.rsp_ready = '1;
        #2;
        vectors++;
        if (bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
        end
        vectors++;
        if (bus.rsp_valid !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid);
        end
        vectors++;
        if (bus.rsp_y !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_rsp_y: got %h expected 0", bus.rsp_y);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
`ifdef SIGMOID_ARB_STALL_CNT_EN
        vectors++;
        if (stall_cnt !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
`endif
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst_n = 1'b1;
        modelReset();
    endtask

    // One request from requester 0 with x = 0
    task automatic test_single();
        applyStimulus(4'b0001, '0, 4'b1111);
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL single_grant: got %b expected 0001", bus.req_ready);
        end
        endCycle();
        applyStimulus('0, '0, 4'b1111);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || bus.rsp_valid !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL single_t1: got busy=%b rsp_valid=%b expected busy=1 rsp_valid=0000", busy, bus.rsp_valid);
        end
        endCycle();
        applyStimulus('0, '0, 4'b1111);
        @(negedge clk);
        vectors++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_y[15:0] !== 16'h00FD || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_t2: got rsp_valid=%b y=%h busy=%b expected 0001 00fd 1", bus.rsp_valid, bus.rsp_y[15:0], busy);
        end
        endCycle();
        applyStimulus('0, '0, 4'b1111);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || bus.rsp_valid !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL single_t3: got busy=%b rsp_valid=%b expected 0 0000", busy, bus.rsp_valid);
        end
        endCycle();
    endtask

    // All four requesters stream continuously
    task automatic test_all_four();
        logic [N*DW-1:0] xs;
        logic [DW-1:0]   yTab [N];
        logic [N-1:0]    want;
        int              j;
        xs = {16'h1000, 16'h0000, 16'hF000, 16'h1000};
        yTab[0] = 16'h0201; yTab[1] = 16'h0000; yTab[2] = 16'h00FD; yTab[3] = 16'h0201;
        applyReset();
        for (int k = 0; k < 12; k++) begin
            applyStimulus('1, xs, '1);
            @(negedge clk);
            want = '0;
            want[k % N] = 1'b1;
            vectors++;
            if (bus.req_ready !== want) begin
                miscompares++;
                $display("[TB] FAIL all4_grant[%0d]: got %b expected %b", k, bus.req_ready, want);
            end
            if (k >= 2) begin
                j = (k - 2) % N;
                want = '0;
                want[j] = 1'b1;
                vectors++;
                if (bus.rsp_valid !== want || bus.rsp_y[j*DW +: DW] !== yTab[j]) begin
                    miscompares++;
                    $display("[TB] FAIL all4_rsp[%0d]: got valid=%b y=%h expected %b %h", k, bus.rsp_valid, bus.rsp_y[j*DW +: DW], want, yTab[j]);
                end
            end
            endCycle();
        end
    endtask

    // Requester 1 holds its response while requester 2 streams
    task automatic test_held_response();
        logic [DW-1:0] x1, x2;
        int cnt1, cnt2;
        x1 = DW'($urandom);
        x2 = DW'($urandom);
        cnt1 = 0;
        cnt2 = 0;
        applyReset();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b0110, {16'h0, x2, x1, 16'h0}, 4'b1101);
            @(negedge clk);
            if (bus.req_ready[1]) cnt1++;
            if (bus.req_ready[2]) cnt2++;
            vectors++;
            if (bus.req_ready !== expReady) begin
                miscompares++;
                $display("[TB] FAIL held_grant[%0d]: got %b expected %b", k, bus.req_ready, expReady);
            end
            if (k >= 2) begin
                vectors++;
                if (bus.rsp_valid[1] !== 1'b1 || bus.rsp_y[31:16] !== refSigmoid(x1)) begin
                    miscompares++;
                    $display("[TB] FAIL held_rsp1[%0d]: got valid=%b y=%h expected 1 %h", k, bus.rsp_valid[1], bus.rsp_y[31:16], refSigmoid(x1));
                end
            end
            endCycle();
        end
        vectors++;
        if (cnt1 != 1 || cnt2 != 5) begin
            miscompares++;
            $display("[TB] FAIL held_counts: got r1=%0d r2=%0d expected r1=1 r2=5", cnt1, cnt2);
        end
    endtask

    // Requester 3 alone: drain and regrant in the same cycle
    task automatic test_back_to_back();
        logic [DW-1:0] xHist [8];
        logic [N-1:0]  want;
        applyReset();
        for (int k = 0; k < 8; k++) begin
            xHist[k] = DW'($urandom);
            applyStimulus(4'b1000, {xHist[k], 48'h0}, 4'b1111);
            @(negedge clk);
            want = (k % 2 == 0) ? 4'b1000 : 4'b0000;
            vectors++;
            if (bus.req_ready !== want) begin
                miscompares++;
                $display("[TB] FAIL b2b_grant[%0d]: got %b expected %b", k, bus.req_ready, want);
            end
            if (k >= 2 && (k % 2 == 0)) begin
                vectors++;
                if (bus.rsp_valid !== 4'b1000 || bus.rsp_y[63:48] !== refSigmoid(xHist[k-2])) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_rsp[%0d]: got valid=%b y=%h expected 1000 %h", k, bus.rsp_valid, bus.rsp_y[63:48], refSigmoid(xHist[k-2]));
                end
            end
            endCycle();
        end
    endtask

    // Reset asserted while an operation is in flight
    task automatic test_reset_mid_op();
        applyReset();
        applyStimulus(4'b0100, {$urandom, $urandom}, '1);
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL midrst_grant: got %b expected 0100", bus.req_ready);
        end
        endCycle();
        applyStimulus(4'b0111, {$urandom, $urandom}, '1);
        #2;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 4'b0000 || bus.rsp_y !== 64'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_outputs: got ready=%b valid=%b y=%h busy=%b expected all zero", bus.req_ready, bus.rsp_valid, bus.rsp_y, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus('0, '0, '1);
            @(negedge clk);
            vectors++;
            if (bus.rsp_valid !== 4'b0000 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL midrst_after[%0d]: got valid=%b busy=%b expected 0000 0", k, bus.rsp_valid, busy);
            end
            endCycle();
        end
        applyStimulus(4'b1010, {$urandom, $urandom}, '1);
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL midrst_first_grant: got %b expected 0010", bus.req_ready);
        end
        endCycle();
    endtask

`ifdef SIGMOID_ARB_STALL_CNT_EN
    // Requester 0 asks while its own response is held
    task automatic test_stall_count();
        applyReset();
        applyStimulus(4'b0001, {$urandom, $urandom}, 4'b0000);
        @(negedge clk);
        vectors++;
        if (stall_cnt !== 32'd0 || bus.req_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL stall_start: got cnt=%0d ready=%b expected 0 0001", stall_cnt, bus.req_ready);
        end
        endCycle();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0001, {$urandom, $urandom}, 4'b0000);
            @(negedge clk);
            vectors++;
            if (bus.req_ready !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL stall_grant[%0d]: got %b expected 0000", k, bus.req_ready);
            end
            endCycle();
        end
        applyStimulus('0, '0, 4'b0000);
        @(negedge clk);
        vectors++;
        if (stall_cnt !== 32'd5) begin
            miscompares++;
            $display("[TB] FAIL stall_count: got %0d expected 5", stall_cnt);
        end
        endCycle();
    endtask
`endif

    // Random traffic against the model, with occasional resets
    task automatic test_random();
        logic [N-1:0] v, r;
        applyReset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) applyReset();
            v = N'($urandom) & N'($urandom | $urandom);
            r = N'($urandom | $urandom);
            applyStimulus(v, {$urandom, $urandom}, r);
            @(negedge clk);
            vectors++;
            if (bus.req_ready !== expReady) begin
                miscompares++;
                $display("[TB] FAIL rand_grant[%0d]: got %b expected %b", k, bus.req_ready, expReady);
            end
            vectors++;
            if (bus.rsp_valid !== mRspValid || bus.rsp_y !== mRspY) begin
                miscompares++;
                $display("[TB] FAIL rand_rsp[%0d]: got valid=%b y=%h expected %b %h", k, bus.rsp_valid, bus.rsp_y, mRspValid, mRspY);
            end
            vectors++;
            if (busy !== (|mPending)) begin
                miscompares++;
                $display("[TB] FAIL rand_busy[%0d]: got %b expected %b", k, busy, |mPending);
            end
`ifdef SIGMOID_ARB_STALL_CNT_EN
            vectors++;
            if (stall_cnt !== 32'(mStall)) begin
                miscompares++;
                $display("[TB] FAIL rand_stall[%0d]: got %0d expected %0d", k, stall_cnt, mStall);
            end
`endif
            endCycle();
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.rsp_ready = '0;
        modelReset();
        expGnt   = -1;
        expReady = '0;
        test_reset();
        test_single();
        test_all_four();
        test_held_response();
        test_back_to_back();
        test_reset_mid_op();
`ifdef SIGMOID_ARB_STALL_CNT_EN
        test_stall_count();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Bound on total run time in case the sequence stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sigmoid_arbiter.md
# sigmoid_arbiter

Round-robin scheduler that shares one `sigmoidPWL` instance among `N_REQ` requesters, such as parallel neuron lanes in the activation stage. Each requester uses a valid/ready handshake. The block issues at most one operand per cycle into the unit and tracks each in-flight operation with a tag pipeline. It returns each result into that requester's one-entry response register.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `DW`, default 16: data width, signed Q6.9 fixed point.
- `PWL_LAT`, default 1: pipeline latency of the sigmoid unit, in cycles.
- `clk`  in  1: the single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  N_REQ: operand valid, one bit per requester.
- `req_x`  in  N_REQ*DW: operands; requester i occupies bits [i*DW +: DW].
- `req_ready`  out  N_REQ: grant; at most one bit is high per cycle.
- `rsp_valid`  out  N_REQ: result valid per requester.
- `rsp_ready`  in  N_REQ: result accept per requester.
- `rsp_y`  out  N_REQ*DW: results, packed the same way as `req_x`.
- `busy`  out  1: OR of all `pending` bits.
- `stall_cnt`  out  32: present only with `SIGMOID_ARB_STALL_CNT_EN`.

## Operation
- Per-requester `pending[i]` bit:
  - Set when the request handshake completes.
  - Cleared when the response handshake completes.
  - Each requester therefore has at most one operation in flight or held.
- Eligibility: `elig[i] = req_valid[i] & (~pending[i] | (rsp_valid[i] & rsp_ready[i]))`. A response drain and a new grant for the same requester can occur in the same cycle.
- Arbitration is round-robin with pointer `ptr`:
  - The search starts at `ptr` and wraps modulo `N_REQ`; the first eligible index g is granted.
  - `req_ready[g] = 1` combinationally; all other `req_ready` bits are 0.
  - After a grant, `ptr <= (g+1) mod N_REQ`. With no grant, `ptr` holds.
- `req_ready` depends on `req_valid` in the same cycle. Requesters must not derive `req_valid` from `req_ready`.
- The granted `req_x[g]` drives the unit input in the same cycle. With no grant, the unit input is 0 and its result is discarded.
- The tag pipeline has `PWL_LAT` stages of `{vld, idx}` and shifts every cycle.
- When the last stage has `vld = 1`:
  - The unit output `y` is written into `rsp_y[idx]`.
  - `rsp_valid[idx]` is set on the same edge.
- `rsp_valid[i]` clears on the `rsp_valid[i] & rsp_ready[i]` edge.
- Set and clear of `rsp_valid[i]` cannot collide: the credit rule guarantees that a write to slot i only follows that slot's drain.
- Results are bit-exact with the unit's output; the block performs no arithmetic on data.

## Timing
- Reset (asynchronous, immediate): `req_ready` = 0 (combinational from the cleared state), `rsp_valid` = 0, `rsp_y` = 0, `busy` = 0, `pending` = 0, `ptr` = 0, all tag `vld` = 0, `stall_cnt` = 0.
- Latency: request handshake in cycle T gives `rsp_valid` high in cycle T+1+`PWL_LAT`, i.e. T+2 at the default.
- Throughput:
  - Single requester with `rsp_ready` held at 1: one result every 2 cycles.
  - Two or more eligible requesters: the unit is used every cycle.
- Reset mid-operation:
  - All in-flight tags are dropped and no response is produced.
  - The unit's internal registers need no coordination, because the tag `vld` bits gate capture.
- `rsp_ready` held low: `rsp_valid`/`rsp_y` hold stable and that requester is never granted. Other requesters are unaffected.
- `req_valid` deasserted without a grant: legal; no state changes.

## Configuration
- `SIGMOID_ARB_STALL_CNT_EN` defined:
  - A 32-bit `stall_cnt` increments each cycle where `|req_valid` is true but no grant is issued.
  - It saturates at 0xFFFFFFFF and clears only on reset.
- Macro undefined: the `stall_cnt` port and its counter are absent. All other behaviour is identical.

## Structure
- Package `sigmoid_arb_pkg`:
  - `DW_C = 16`, `FRAC_BITS = 9`, `ONE_Q = 16'h0200`.
  - Typedef `tag_t` holding `{logic vld; logic [2:0] idx;}`.
- Sub-module `rr_arbiter` (parameter `N`):
  - Inputs: `elig`, `ptr`.
  - Outputs: one-hot `gnt` and encoded `gnt_idx`.
  - Purely combinational; the pointer register lives in the top level.
- `sigmoidPWL` is instantiated once, with `clk`/`rst_n` passed through.

## Test plan
- Single request, requester 0, `req_x[0] = 16'h0000`, `rsp_ready` = 1 → handshake at T; `rsp_valid[0]` at T+2 with `rsp_y[0] = 16'h00FD`; `busy` high T+1..T+2.
- All 4 requesters valid continuously, with x = 16'h1000, 16'hF000, 16'h0000, 16'h1000 → grant order 0,1,2,3,0…; results are 16'h0201, 16'h0000, 16'h00FD, 16'h0201, each 2 cycles after its grant; one grant per cycle.
- Requester 1 with `rsp_ready[1]` = 0 for 10 cycles while requester 2 streams → requester 1 gets exactly one grant; its `rsp_y` holds stable; requester 2 gets one grant every 2 cycles.
- Same-cycle drain and regrant: requester 3 alone with `rsp_ready[3]` = 1 → grants at T, T+2, T+4; no gaps beyond the 2-cycle cadence.
- Assert `rst_n` low one cycle after a grant → all outputs go to 0 immediately; no `rsp_valid` after release; first post-reset grant goes to the lowest valid index.
- With `SIGMOID_ARB_STALL_CNT_EN`, requester 0 valid while its response is held (`rsp_ready[0]` = 0) for 5 cycles → `stall_cnt` increases by exactly 5.
